mult_div_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit for the MIPS-style datapath.
- Sits directly downstream of register_file. It consumes Read_Data_1 and Read_Data_2 as Operand_A and Operand_B.
- Results go to architectural HI/LO registers; MFHI/MFLO read them later for writeback.
- Handles MULT, MULTU, DIV and DIVU with one shared shift/add-subtract datapath (one bit per clock).

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per clock, into HI/LO.
// Ports: clk, Reset, Start, Op, Operand_A/B in; Busy, Done, Div_By_Zero, Hi, Lo out.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic             load;
  logic             last;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dbz;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             sgn_op;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  assign last = (cnt == '0);

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (last) state_nxt = FIN;
      end
      FIN: begin
        Done = 1'b1;
        if (Start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Div_By_Zero = Done & dbz;

  assign sgn_op = Op[0];
  assign sgn_a  = sgn_op & Operand_A[WIDTH-1];
  assign sgn_b  = sgn_op & Operand_B[WIDTH-1];

  // Multiply: add multiplicand into the upper half when the
  // multiplier LSB (held in acc_lo) is set, then shift right.
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);

  // Restoring divide: acc_lo shifts dividend out, quotient in.
  assign rsh  = {acc_hi, acc_lo[WIDTH-1]};
  assign diff = rsh - {1'b0, mag_b};
  assign ge   = ~diff[WIDTH];

  always_comb begin
    if (is_div) begin
      it_hi = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
      it_lo = {acc_lo[WIDTH-2:0], ge};
    end else begin
      it_hi = sum[WIDTH:1];
      it_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up folded into the final HI/LO write.
  always_comb begin
    prod   = {it_hi, it_lo};
    fin_hi = it_hi;
    fin_lo = it_lo;
    if (!is_div) begin
      if (neg_q) prod = -prod;
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (dbz) begin
      fin_hi = a_orig;
      fin_lo = '1;
    end else begin
      if (neg_q) fin_lo = -it_lo;
      if (neg_r) fin_hi = -it_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      a_orig <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      Hi     <= '0;
      Lo     <= '0;
    end else if (load) begin
      cnt    <= CW'(WIDTH - 1);
      is_div <= Op[1];
      neg_q  <= sgn_a ^ sgn_b;
      neg_r  <= sgn_a;
      dbz    <= Op[1] & (Operand_B == '0);
      a_orig <= Operand_A;
      mag_a  <= sgn_a ? -Operand_A : Operand_A;
      mag_b  <= sgn_b ? -Operand_B : Operand_B;
      acc_hi <= '0;
      // Divide loads the dividend magnitude, multiply the multiplier.
      if (Op[1]) acc_lo <= sgn_a ? -Operand_A : Operand_A;
      else       acc_lo <= sgn_b ? -Operand_B : Operand_B;
    end else if (state == RUN) begin
      cnt    <= cnt - 1'b1;
      acc_hi <= it_hi;
      acc_lo <= it_lo;
      if (last) begin
        Hi <= fin_hi;
        Lo <= fin_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Operand_A;
  logic [31:0] Operand_B;
  logic        Busy;
  logic        Done;
  logic        Div_By_Zero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .Reset(Reset),
    .Start(Start),
    .Op(Op),
    .Operand_A(Operand_A),
    .Operand_B(Operand_B),
    .Busy(Busy),
    .Done(Done),
    .Div_By_Zero(Div_By_Zero),
    .Hi(Hi),
    .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      2'd0: return {32'b0, a} * {32'b0, b};
      2'd1: return sa * sb;
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at a negedge: drives the request for the next posedge.
  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    Start     = 1'b1;
    Op        = op;
    Operand_A = a;
    Operand_B = b;
  endtask

  // Follows one operation to its Done cycle; returns at that negedge
  // with Start low so the caller may chain another issue.
  task automatic wait_done(input logic [1:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input bit noisy);
    logic [63:0] m;
    logic [31:0] h0, l0;
    logic        dz;
    int          busy_n;
    bit          seen;
    m      = model(op, a, b);
    dz     = op[1] && (b == 0);
    h0     = Hi;
    l0     = Lo;
    busy_n = 0;
    seen   = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (Done) begin
        Start = 1'b0;
        seen  = 1;
        chk("latency", n, 33);
        chk("busy_cycles", busy_n, 32);
        chk("hi", Hi, m[63:32]);
        chk("lo", Lo, m[31:0]);
        chk("dbz", {31'b0, Div_By_Zero}, {31'b0, dz});
      end else begin
        if (n == 1) chk("busy_rise", {31'b0, Busy}, 32'd1);
        if (n == 16) begin
          chk("hold_hi", Hi, h0);
          chk("hold_lo", Lo, l0);
          chk("dbz_run", {31'b0, Div_By_Zero}, 32'd0);
        end
        if (Busy) busy_n++;
        if (noisy) begin
          Start     = 1'($urandom);
          Op        = 2'($urandom);
          Operand_A = $urandom;
          Operand_B = $urandom;
        end else begin
          Start = 1'b0;
        end
      end
    end
    if (!seen) begin
      Start = 1'b0;
      chk("done_timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          ndone;

    Reset     = 1'b1;
    Start     = 1'b0;
    Op        = 2'd0;
    Operand_A = '0;
    Operand_B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_dbz", {31'b0, Div_By_Zero}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    Reset = 1'b0;
    @(negedge clk);

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max_hi", Hi, 32'hFFFF_FFFE);
    chk("multu_max_lo", Lo, 32'h0000_0001);

    @(negedge clk);
    issue(2'd1, 32'hFFFF_FFFD, 32'd5);
    wait_done(2'd1, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_neg_lo", Lo, 32'hFFFF_FFF1);

    @(negedge clk);
    issue(2'd1, 32'h8000_0000, 32'h8000_0000);
    wait_done(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
    chk("mult_min_hi", Hi, 32'h4000_0000);

    @(negedge clk);
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg_lo", Lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", Hi, 32'hFFFF_FFFF);

    @(negedge clk);
    issue(2'd2, 32'd100, 32'd7);
    wait_done(2'd2, 32'd100, 32'd7, 0);
    chk("divu_lo", Lo, 32'd14);
    chk("divu_hi", Hi, 32'd2);

    @(negedge clk);
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_wrap_lo", Lo, 32'h8000_0000);
    chk("div_wrap_hi", Hi, 32'd0);

    @(negedge clk);
    issue(2'd2, 32'h64, 32'd0);
    wait_done(2'd2, 32'h64, 32'd0, 0);
    chk("dbz_hi", Hi, 32'h64);
    chk("dbz_lo", Lo, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("dbz_after", {31'b0, Div_By_Zero}, 32'd0);
    issue(2'd0, 32'd2, 32'd3);
    wait_done(2'd0, 32'd2, 32'd3, 0);
    chk("after_dbz_lo", Lo, 32'd6);

    @(negedge clk);
    issue(2'd3, 32'hFFFF_FF00, 32'd0);
    wait_done(2'd3, 32'hFFFF_FF00, 32'd0, 0);

    // Noise on Start/Op/operands during RUN must be ignored.
    @(negedge clk);
    issue(2'd1, 32'hFFFF_FFFD, 32'd5);
    wait_done(2'd1, 32'hFFFF_FFFD, 32'd5, 1);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (Done) ndone++;
    end
    chk("single_done", ndone, 0);

    // Abort by reset mid-operation.
    issue(2'd2, 32'h3412, 32'h100);
    wait_done(2'd2, 32'h3412, 32'h100, 0);
    chk("pre_hi", Hi, 32'h12);
    chk("pre_lo", Lo, 32'h34);
    @(negedge clk);
    issue(2'd0, 32'd7, 32'd9);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    chk("abort_busy_pre", {31'b0, Busy}, 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_hi", Hi, 32'd0);
    chk("abort_lo", Lo, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // Back-to-back issue in the FIN cycle.
    issue(2'd0, 32'd3, 32'd4);
    wait_done(2'd0, 32'd3, 32'd4, 0);
    issue(2'd3, 32'd1000, 32'hFFFF_FFFD);
    wait_done(2'd3, 32'd1000, 32'hFFFF_FFFD, 0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      issue(rop, ra, rb);
      wait_done(rop, ra, rb, 0);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
